hough_peak_reader: RTL

HOUGH_PEAK_READER -- requirements
Module: hough_peak_reader

---
 rtl/hough_peak_reader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/hough_peak_reader.sv
// rtl/hough_peak_reader.sv - raster-scans a Hough accumulator and reports the strongest left/right cells
// Two peaks are delivered per scan: left half of theta first, then right half.
module hough_peak_reader #(
    parameter int MSB_R     = 11,
    parameter int MSB_PHI   = 7,
    parameter int MSB       = 15,
    parameter int R_MAX     = 2047,
    parameter int PHI_MAX   = 179,
    parameter int PHI_SPLIT = 90
) (
    input  logic             clk,
    input  logic             reset_peak,
    input  logic             start,
    input  logic [MSB:0]     threshold,
    output logic [MSB_R:0]   rd_r,
    output logic [MSB_PHI:0] rd_phi,
    output logic             rd_en,
    input  logic [MSB:0]     rd_data,
    output logic             busy,
    output logic             peak_valid,
    input  logic             peak_ready,
    output logic [MSB_R:0]   peak_r,
    output logic [MSB_PHI:0] peak_phi,
    output logic [MSB:0]     peak_cnt,
    output logic             peak_side,
    output logic             peak_found
);

    localparam logic [MSB_R:0]   R_LAST   = (MSB_R + 1)'(R_MAX);
    localparam logic [MSB_PHI:0] PHI_LAST = (MSB_PHI + 1)'(PHI_MAX);
    localparam logic [MSB_PHI:0] PHI_MID  = (MSB_PHI + 1)'(PHI_SPLIT);

    typedef enum logic [2:0] {IDLE, SCAN, DRAIN, OUT_L, OUT_R} state_t;

    state_t           state;
    state_t           state_nx;
    logic             last_addr;
    logic             start_ok;
    logic             p_valid;
    logic [MSB_R:0]   p_r;
    logic [MSB_PHI:0] p_phi;
    logic             p_side;
    logic             upd;
    logic [MSB:0]     thr;
    logic [1:0]       best_found;
    logic [MSB_R:0]   best_r   [2];
    logic [MSB_PHI:0] best_phi [2];
    logic [MSB:0]     best_cnt [2];
    logic             sel;

    assign last_addr = (rd_r == R_LAST) && (rd_phi == PHI_LAST);
    assign start_ok  = start && (state == IDLE);
    assign p_side    = (p_phi >= PHI_MID);
    // Strict '>' against an existing best keeps the earliest cell on ties.
    assign upd       = p_valid && (rd_data >= thr) &&
                       (!best_found[p_side] || (rd_data > best_cnt[p_side]));

    always_ff @(posedge clk) begin
        if (reset_peak) state <= IDLE;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start)      state_nx = SCAN;
            SCAN:    if (last_addr)  state_nx = DRAIN;
            DRAIN:                   state_nx = OUT_L;
            OUT_L:   if (peak_ready) state_nx = OUT_R;
            OUT_R:   if (peak_ready) state_nx = IDLE;
            default:                 state_nx = IDLE;
        endcase
    end

    always_comb begin
        rd_en      = (state == SCAN);
        busy       = (state != IDLE);
        peak_valid = (state == OUT_L) || (state == OUT_R);
        peak_side  = (state == OUT_R);
        sel        = peak_side;
        peak_found = 1'b0;
        peak_r     = '0;
        peak_phi   = '0;
        peak_cnt   = '0;
        if (peak_valid && best_found[sel]) begin
            peak_found = 1'b1;
            peak_r     = best_r[sel];
            peak_phi   = best_phi[sel];
            peak_cnt   = best_cnt[sel];
        end
    end

    always_ff @(posedge clk) begin
        if (reset_peak) begin
            rd_r       <= '0;
            rd_phi     <= '0;
            p_valid    <= 1'b0;
            p_r        <= '0;
            p_phi      <= '0;
            thr        <= '0;
            best_found <= '0;
            for (int s = 0; s < 2; s++) begin
                best_r[s]   <= '0;
                best_phi[s] <= '0;
                best_cnt[s] <= '0;
            end
        end else begin
            // Address of the read issued this cycle travels alongside its data.
            p_valid <= rd_en;
            p_r     <= rd_r;
            p_phi   <= rd_phi;
            if (state == SCAN) begin
                if (last_addr) begin
                    rd_r   <= '0;
                    rd_phi <= '0;
                end else if (rd_phi == PHI_LAST) begin
                    rd_phi <= '0;
                    rd_r   <= rd_r + 1'b1;
                end else begin
                    rd_phi <= rd_phi + 1'b1;
                end
            end
            if (start_ok) begin
                thr        <= threshold;
                best_found <= '0;
                for (int s = 0; s < 2; s++) begin
                    best_r[s]   <= '0;
                    best_phi[s] <= '0;
                    best_cnt[s] <= '0;
                end
            end else if (upd) begin
                best_found[p_side] <= 1'b1;
                best_r[p_side]     <= p_r;
                best_phi[p_side]   <= p_phi;
                best_cnt[p_side]   <= rd_data;
            end
        end
    end

endmodule
